// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: word width, the canonical NOP encoding and the
// fetch-queue entry layout.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 style bubble: add x0, x0, x0
    localparam logic [XLEN-1:0] NOP                = 32'h0000_0033;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fqEntry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs between instruction memory and FD.
// Flush beats push; popping an empty queue does nothing.
module fetch_queue
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push,
    input  fqEntry_t  pushData,
    input  logic      pop,
    input  logic      flush,
    output fqEntry_t  head,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    fqEntry_t      mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPop;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign doPop = pop && (count != '0);
    assign head  = mem[rdPtr];

    always_ff @(posedge clk_i) begin
        if (!reset_i || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (doPop) rdPtr <= nextPtr(rdPtr);
            case ({push, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (reset_i && !flush && push) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i && !flush && push && !doPop) assert (count != FULL);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps up to FQ_DEPTH requests in flight,
// drops wrong-path responses after redirects and feeds the FD register.
module fetch_unit
    import riscv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int              FQ_DEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            F_stall_i,
    input  logic            D_flush_i,
    input  logic            D_predictPC_i,
    input  logic [XLEN-1:0] D_PCprediction_i,
    input  logic            E_correctPC_i,
    input  logic [XLEN-1:0] E_PCcorrection_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] FD_PC_o,
    output logic [XLEN-1:0] FD_instr_o,
    output logic            FD_nop_o
);

    localparam int QAW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    // Outstanding can reach 2*FQ_DEPTH (live plus to-be-discarded); the sum
    // with the queue count must not wrap.
    localparam int              CW      = QAW + 2;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FQ_DEPTH);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] respPc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   inFlight;
    logic [QAW:0]    qCount;
    fqEntry_t        qHead;
    fqEntry_t        rspEntry;
    logic            redirect;
    logic            grant;
    logic            rspBeat;
    logic            accepted;
    logic            fdLoad;
    logic            fdBubble;
    logic            qPop;
    logic            qPush;
    logic            bypass;

    assign redirect = E_correctPC_i || (D_predictPC_i && !F_stall_i);
    assign target   = E_correctPC_i ? E_PCcorrection_i : D_PCprediction_i;

    // Memory handshake: a request transfers on any cycle with imem_req_o and
    // imem_gnt_i both high; until then imem_addr_o stays put. Responses come
    // back in order, one per imem_rvalid_i beat, with no back-pressure.
    assign inFlight    = CW'(qCount) + outstanding - discard;
    assign imem_req_o  = reset_i && !redirect && (inFlight < DEPTH_C);
    assign imem_addr_o = fetchPc;
    assign grant       = imem_req_o && imem_gnt_i;

    // Beats with nothing outstanding are leftovers from before a reset.
    assign rspBeat  = reset_i && imem_rvalid_i && (outstanding != '0);
    assign accepted = rspBeat && (discard == '0);
    assign rspEntry = '{pc: respPc, instr: imem_rdata_i};

    assign fdLoad   = !F_stall_i;
    assign fdBubble = D_flush_i || redirect;
    assign qPop     = fdLoad && !fdBubble;
    assign bypass   = fdLoad && !fdBubble && (qCount == '0) && accepted;
    assign qPush    = accepted && !bypass;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .push     (qPush),
        .pushData (rspEntry),
        .pop      (qPop),
        .flush    (redirect),
        .head     (qHead),
        .count    (qCount)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fetchPc     <= RESET_ADDR;
            respPc      <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
            FD_PC_o     <= '0;
            FD_instr_o  <= NOP;
            FD_nop_o    <= 1'b1;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rspBeat);
            if (redirect) begin
                fetchPc <= target;
                respPc  <= target;
                // Everything still in flight after this cycle is wrong-path.
                discard <= outstanding - CW'(rspBeat);
            end else begin
                if (grant)    fetchPc <= fetchPc + 32'd4;
                if (accepted) respPc  <= respPc + 32'd4;
                if (rspBeat && (discard != '0)) discard <= discard - 1'b1;
            end

            if (fdLoad) begin
                if (!fdBubble && (qCount != '0)) begin
                    FD_PC_o    <= qHead.pc;
                    FD_instr_o <= qHead.instr;
                    FD_nop_o   <= 1'b0;
                end else if (bypass) begin
                    FD_PC_o    <= rspEntry.pc;
                    FD_instr_o <= rspEntry.instr;
                    FD_nop_o   <= 1'b0;
                end else begin
                    FD_instr_o <= NOP;
                    FD_nop_o   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder, program-flow reference model
// (expected next PC plus expected-PC queue) and directed redirect scenarios.
module tb_fetch_unit;
  import riscv_pipe_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        F_stall_i = 1'b0;
  logic        D_flush_i = 1'b0;
  logic        D_predictPC_i = 1'b0;
  logic [31:0] D_PCprediction_i = '0;
  logic        E_correctPC_i = 1'b0;
  logic [31:0] E_PCcorrection_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] FD_PC_o;
  logic [31:0] FD_instr_o;
  logic        FD_nop_o;

  fetch_unit #(.RESET_ADDR(RST_A), .FQ_DEPTH(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .F_stall_i(F_stall_i), .D_flush_i(D_flush_i),
    .D_predictPC_i(D_predictPC_i), .D_PCprediction_i(D_PCprediction_i),
    .E_correctPC_i(E_correctPC_i), .E_PCcorrection_i(E_PCcorrection_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .FD_PC_o(FD_PC_o), .FD_instr_o(FD_instr_o), .FD_nop_o(FD_nop_o)
  );

  // clock / reset
  initial forever #5 clk_i = ~clk_i;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | (r & 32'h0000_000C);
    return {r[31:2], 2'b00};
  endfunction

  // memory model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;
  int          grants_total = 0;

  // reference model / scoreboard state
  logic [31:0] exp_pc = RST_A;
  logic [31:0] exp_q[$];
  int          deliveries = 0;
  bit          dlv_now = 1'b0;
  logic [31:0] last_dlv_pc = '0;

  // One clock: capture pre-edge inputs/handshake, advance, drive memory, check FD.
  task automatic tick();
    logic fire, rst_p, st_p, fl_p, dp_p, ec_p, nop_p;
    logic [31:0] faddr, dt_p, et_p, pc_p, in_p;
    int due;
    @(negedge clk_i);
    fire = imem_req_o && imem_gnt_i;
    faddr = imem_addr_o;
    rst_p = reset_i; st_p = F_stall_i; fl_p = D_flush_i;
    dp_p = D_predictPC_i; dt_p = D_PCprediction_i;
    ec_p = E_correctPC_i; et_p = E_PCcorrection_i;
    pc_p = FD_PC_o; in_p = FD_instr_o; nop_p = FD_nop_o;
    @(posedge clk_i);
    #1;
    cyc++;
    if (!rst_p) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
    end
    if (fire) begin
      grants_total++;
      due = cyc - 1 + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      pend_addr.push_back(faddr);
      pend_due.push_back(due);
      last_due = due;
    end
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i = $urandom;
    end
    imem_gnt_i = ($urandom_range(99) < gnt_pct);

    dlv_now = 1'b0;
    if (!rst_p) begin
      check_val("rst_nop", FD_nop_o, 1);
      check_val("rst_instr", FD_instr_o, NOP);
      check_val("rst_pc", FD_PC_o, 32'h0);
      exp_pc = RST_A;
    end else if (st_p) begin
      check_val("stall_hold_nop", FD_nop_o, nop_p);
      check_val("stall_hold_pc", FD_PC_o, pc_p);
      check_val("stall_hold_instr", FD_instr_o, in_p);
      if (ec_p) exp_pc = et_p;
    end else begin
      if (ec_p || dp_p || fl_p) begin
        check_val("flush_bubble", FD_nop_o, 1);
        check_val("flush_instr", FD_instr_o, NOP);
      end else if (!FD_nop_o) begin
        check_val("dlv_pc", FD_PC_o, exp_pc);
        check_val("dlv_instr", FD_instr_o, mem_word(exp_pc));
        deliveries++;
        dlv_now = 1'b1;
        last_dlv_pc = FD_PC_o;
        if (exp_q.size() > 0) check_val("seq_pc", FD_PC_o, exp_q.pop_front());
        exp_pc = exp_pc + 32'd4;
      end else begin
        check_val("bubble_instr", FD_instr_o, NOP);
      end
      if (ec_p) exp_pc = et_p;
      else if (dp_p) exp_pc = dt_p;
    end
  endtask

  // driver tasks
  task automatic set_idle();
    F_stall_i = 1'b0; D_flush_i = 1'b0; D_predictPC_i = 1'b0; E_correctPC_i = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
  endtask

  task automatic drain_exp(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic wait_dlv(input string tag, input logic [31:0] pc, input int budget);
    int n = 0;
    dlv_now = 1'b0;
    while (!(dlv_now && last_dlv_pc == pc) && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, (dlv_now && last_dlv_pc == pc), 1);
  endtask

  initial begin
    int g0;
    bit found;
    int n;

    // reset state and first-fetch latency
    set_idle();
    #1;
    check_val("req_in_reset", imem_req_o, 0);
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    check_val("req_after_rst", imem_req_o, 1);
    check_val("addr_after_rst", imem_addr_o, RST_A);
    for (int i = 0; i < 8; i++) exp_q.push_back(RST_A + 32'(4 * i));
    tick();
    check_val("lat_first_bubble", FD_nop_o, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("lat_stream_valid", FD_nop_o, 0);
    end
    check_val("lat_seq_done", exp_q.size(), 0);

    // stall mid-stream
    g0 = grants_total;
    F_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("stall_grants_le2", ((grants_total - g0) <= 2), 1);
    F_stall_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // decode prediction at PC 0x10
    do_reset();
    wait_dlv("wait_pc10", 32'h10, 50);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    D_predictPC_i = 1'b1;
    D_PCprediction_i = 32'h100;
    tick();
    D_predictPC_i = 1'b0;
    check_val("pred_bubble", FD_nop_o, 1);
    drain_exp("pred_seq", 20);

    // execute correction with two requests in flight
    lat_min = 3;
    lat_max = 3;
    do_reset();
    n = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      tick();
      n++;
      found = (pend_addr.size() == 2) && (pend_addr[0] >= 32'h20);
    end
    check_val("two_outstanding", found, 1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    E_correctPC_i = 1'b1;
    E_PCcorrection_i = 32'h200;
    tick();
    E_correctPC_i = 1'b0;
    check_val("corr_bubble", FD_nop_o, 1);
    drain_exp("corr_seq", 30);

    // E and D together, then back-to-back E
    lat_min = 1;
    lat_max = 2;
    for (int i = 0; i < 4; i++) tick();
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h504);
    E_correctPC_i = 1'b1; E_PCcorrection_i = 32'h300;
    D_predictPC_i = 1'b1; D_PCprediction_i = 32'h400;
    tick();
    D_predictPC_i = 1'b0;
    E_PCcorrection_i = 32'h500;
    tick();
    E_correctPC_i = 1'b0;
    drain_exp("ed_seq", 30);

    // reset while requests are in flight
    for (int i = 0; i < 3; i++) tick();
    reset_i = 1'b0;
    #1;
    check_val("req_midrst", imem_req_o, 0);
    exp_q.push_back(RST_A);
    exp_q.push_back(RST_A + 32'd4);
    tick();
    reset_i = 1'b1;
    drain_exp("rst_restart_seq", 30);

    // wrap-around at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    E_correctPC_i = 1'b1;
    E_PCcorrection_i = 32'hFFFF_FFFC;
    tick();
    E_correctPC_i = 1'b0;
    drain_exp("wrap_seq", 30);

    // randomized traffic
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      F_stall_i = ($urandom_range(99) < 20);
      D_flush_i = ($urandom_range(99) < 4);
      D_predictPC_i = ($urandom_range(99) < 6);
      D_PCprediction_i = rand_target();
      E_correctPC_i = ($urandom_range(99) < 4);
      E_PCcorrection_i = rand_target();
      reset_i = ($urandom_range(999) >= 3);
      tick();
    end
    set_idle();
    reset_i = 1'b1;
    gnt_pct = 100;
    for (int i = 0; i < 20; i++) tick();
    check_val("exp_q_empty", exp_q.size(), 0);
    check_val("liveness", (deliveries > 200), 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
